instrn_fetch_queue: RTL and testbench

- Parametrised next-generation instruction fetch stage for the idealRISC pipeline.
- Drives the synchronous-read instruction BRAM (1-cycle read latency) and keeps a DEPTH-entry prefetch queue of {pc, instr} pairs.
- Presents entries to decode via a valid/ready handshake; substitutes NOP whenever the queue is empty.
- Supports branch redirect with queue and in-flight flush, back-pressure, and halt at end of instruction memory.

---
 rtl/idealrisc_pkg.sv | 14 +
 rtl/instrn_fetch_queue_if.sv | 29 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instrn_fetch_queue.sv | 100 ++++++++++
 tb/tb_instrn_fetch_queue.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idealrisc_pkg.sv
// Shared widths, NOP encoding and prefetch entry type for the idealRISC fetch stage.
package idealrisc_pkg;

  localparam int unsigned ADDR_W_DEF  = 11;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = {6'b111111, 26'b0};

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/instrn_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction BRAM port, redirect input and decode handshake.
interface instrn_fetch_queue_if #(
  parameter int unsigned ADDR_W  = idealrisc_pkg::ADDR_W_DEF,
  parameter int unsigned INSTR_W = idealrisc_pkg::INSTR_W_DEF
);

  logic               imem_rd_en;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;
  logic               fetch_halted;

  // master is the fetch stage, slave is memory plus decode
  modport master (
    output imem_rd_en, imem_addr, out_valid, out_instr, out_pc, fetch_halted,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, out_valid, out_instr, out_pc, fetch_halted,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of prefetch entries with flush; count is exposed for credit tracking.
module fetch_fifo
  import idealrisc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fq_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T              mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // flush dominates any push/pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + CW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + CW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push_i && !flush_i) |-> (count_q != CW'(DEPTH)));

endmodule

// File: rtl/instrn_fetch_queue.sv
// idealRISC fetch stage: issues BRAM reads under queue credit, queues {pc, instr} for decode,
// flushes on redirect and stops fetching after the last memory word.
module instrn_fetch_queue
  import idealrisc_pkg::*;
#(
  parameter int unsigned        ADDR_W    = ADDR_W_DEF,
  parameter int unsigned        INSTR_W   = INSTR_W_DEF,
  parameter int unsigned        DEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input logic                  clk,
  input logic                  rst,
  instrn_fetch_queue_if.master bus
);

  localparam int unsigned       CW       = $clog2(DEPTH) + 1;
  localparam int unsigned       OW       = CW + 1;
  localparam logic [ADDR_W-1:0] LAST_PC  = '1;
  localparam logic [OW-1:0]     DEPTH_OW = OW'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic              started_q;
  logic              halted_q, halted_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;

  logic [CW-1:0]     count;
  logic [OW-1:0]     occupancy;
  logic              head_valid, pop, push, issue;
  entry_t            head, push_entry;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .flush_i     (bus.redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  // Credit check counts queued entries plus the read in flight, minus this cycle's pop.
  always_comb begin
    head_valid       = (count != '0);
    pop              = head_valid & bus.out_ready;
    push             = inflight_q & ~bus.redirect_valid;
    push_entry.pc    = issue_pc_q;
    push_entry.instr = bus.imem_rdata;
    occupancy        = OW'(count) + OW'(inflight_q) - OW'(pop);
    issue            = started_q & ~halted_q & ~bus.redirect_valid & (occupancy < DEPTH_OW);

    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    inflight_d = 1'b0;
    issue_pc_d = issue_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      halted_d   = 1'b0;
    end else if (issue) begin
      inflight_d = 1'b1;
      issue_pc_d = fetch_pc_q;
      if (fetch_pc_q == LAST_PC) halted_d   = 1'b1;
      else                       fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q  <= 1'b0;
      halted_q   <= 1'b0;
      inflight_q <= 1'b0;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
    end else begin
      started_q  <= 1'b1;
      halted_q   <= halted_d;
      inflight_q <= inflight_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
    end
  end

  assign bus.imem_rd_en   = issue;
  assign bus.imem_addr    = fetch_pc_q;
  assign bus.out_valid    = head_valid;
  assign bus.out_pc       = head_valid ? head.pc : '0;
  assign bus.out_instr    = head_valid ? head.instr : NOP_INSTR;
  assign bus.fetch_halted = halted_q;

endmodule

// File: tb/tb_instrn_fetch_queue.sv
// Bench for instrn_fetch_queue: directed latency/flush/halt scenarios plus a randomized
// stream checked against an in-order delivery and credit model.
module tb_instrn_fetch_queue;

  localparam int unsigned AW_A  = 11;
  localparam int unsigned AW_B  = 4;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [IW-1:0] NOP = {6'b111111, 26'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  instrn_fetch_queue_if #(.ADDR_W(AW_A), .INSTR_W(IW)) bus_a ();
  instrn_fetch_queue_if #(.ADDR_W(AW_B), .INSTR_W(IW)) bus_b ();

  instrn_fetch_queue #(.ADDR_W(AW_A), .INSTR_W(IW), .DEPTH(DEPTH)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a));

  instrn_fetch_queue #(.ADDR_W(AW_B), .INSTR_W(IW), .DEPTH(DEPTH)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b));

  // instruction memory: mem[i] = i + 100, one-cycle read latency
  always @(posedge clk) begin
    if (bus_a.imem_rd_en) bus_a.imem_rdata <= IW'(bus_a.imem_addr) + IW'(100);
    if (bus_b.imem_rd_en) bus_b.imem_rdata <= IW'(bus_b.imem_addr) + IW'(100);
  end

  task automatic cyc_a(input logic rdy, input logic rv, input logic [AW_A-1:0] rpc);
    @(negedge clk);
    bus_a.out_ready      = rdy;
    bus_a.redirect_valid = rv;
    bus_a.redirect_pc    = rpc;
    #1;
  endtask

  task automatic cyc_b(input logic rdy, input logic rv, input logic [AW_B-1:0] rpc);
    @(negedge clk);
    bus_b.out_ready      = rdy;
    bus_b.redirect_valid = rv;
    bus_b.redirect_pc    = rpc;
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({bus_a.out_valid, bus_a.out_instr, bus_a.out_pc, bus_a.imem_rd_en, bus_a.imem_addr,
         bus_a.fetch_halted} !== {1'b0, NOP, 11'd0, 1'b0, 11'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b i=%h pc=%0d rd=%b a=%0d h=%b want 0/%h/0/0/0/0",
               bus_a.out_valid, bus_a.out_instr, bus_a.out_pc, bus_a.imem_rd_en,
               bus_a.imem_addr, bus_a.fetch_halted, NOP);
    end
    tests++;
    if ({bus_b.out_valid, bus_b.imem_rd_en, bus_b.fetch_halted} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs_b: got %b want 000",
               {bus_b.out_valid, bus_b.imem_rd_en, bus_b.fetch_halted});
    end
  endtask

  task automatic test_startup();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if (bus_a.imem_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL startup_rd_before_e1: got %b want 0", bus_a.imem_rd_en);
    end
    cyc_a(1'b1, 1'b0, '0);
    tests++;
    if ({bus_a.imem_rd_en, bus_a.imem_addr, bus_a.out_valid, bus_a.out_instr}
        !== {1'b1, 11'd0, 1'b0, NOP}) begin
      fails++;
      $display("FAIL startup_c1: got rd=%b a=%0d v=%b i=%h want 1/0/0/%h",
               bus_a.imem_rd_en, bus_a.imem_addr, bus_a.out_valid, bus_a.out_instr, NOP);
    end
    cyc_a(1'b1, 1'b0, '0);
    tests++;
    if ({bus_a.out_valid, bus_a.imem_rd_en, bus_a.imem_addr} !== {1'b0, 1'b1, 11'd1}) begin
      fails++;
      $display("FAIL startup_c2: got v=%b rd=%b a=%0d want 0/1/1",
               bus_a.out_valid, bus_a.imem_rd_en, bus_a.imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      cyc_a(1'b1, 1'b0, '0);
      tests++;
      if ({bus_a.out_valid, bus_a.out_pc, bus_a.out_instr}
          !== {1'b1, AW_A'(k), IW'(k + 100)}) begin
        fails++;
        $display("FAIL startup_stream: got v=%b pc=%0d i=%0d want 1/%0d/%0d",
                 bus_a.out_valid, bus_a.out_pc, bus_a.out_instr, k, k + 100);
      end
    end
  endtask

  task automatic test_redirect();
    logic [AW_A-1:0] exp_pc;
    bit              found;
    exp_pc = 11'd4;
    found  = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc_a(1'b1, 1'b0, '0);
      if (bus_a.out_valid === 1'b1) begin
        tests++;
        if (bus_a.out_pc !== exp_pc) begin
          fails++;
          $display("FAIL redirect_prestream: got pc=%0d want %0d", bus_a.out_pc, exp_pc);
        end
        exp_pc++;
      end
      if (bus_a.imem_rd_en === 1'b1 && bus_a.imem_addr === 11'd7) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL redirect_wait_addr7: got found=0 want 1");
    end
    cyc_a(1'b1, 1'b1, 11'd40);
    tests++;
    if ({bus_a.imem_rd_en, bus_a.out_valid, bus_a.out_pc} !== {1'b0, 1'b1, exp_pc}) begin
      fails++;
      $display("FAIL redirect_cycle: got rd=%b v=%b pc=%0d want 0/1/%0d",
               bus_a.imem_rd_en, bus_a.out_valid, bus_a.out_pc, exp_pc);
    end
    cyc_a(1'b1, 1'b0, '0);
    tests++;
    if ({bus_a.out_valid, bus_a.imem_rd_en, bus_a.imem_addr} !== {1'b0, 1'b1, 11'd40}) begin
      fails++;
      $display("FAIL redirect_c1: got v=%b rd=%b a=%0d want 0/1/40",
               bus_a.out_valid, bus_a.imem_rd_en, bus_a.imem_addr);
    end
    cyc_a(1'b1, 1'b0, '0);
    tests++;
    if (bus_a.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL redirect_c2_stale: got v=%b pc=%0d want v=0", bus_a.out_valid, bus_a.out_pc);
    end
    for (int k = 0; k < 2; k++) begin
      cyc_a(1'b1, 1'b0, '0);
      tests++;
      if ({bus_a.out_valid, bus_a.out_pc, bus_a.out_instr}
          !== {1'b1, AW_A'(40 + k), IW'(140 + k)}) begin
        fails++;
        $display("FAIL redirect_target: got v=%b pc=%0d i=%0d want 1/%0d/%0d",
                 bus_a.out_valid, bus_a.out_pc, bus_a.out_instr, 40 + k, 140 + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc_a(1'b1, 1'b1, 11'd50);
    cyc_a(1'b1, 1'b1, 11'd60);
    tests++;
    if (bus_a.imem_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL b2b_rd_during_redirect: got %b want 0", bus_a.imem_rd_en);
    end
    cyc_a(1'b1, 1'b0, '0);
    tests++;
    if ({bus_a.imem_rd_en, bus_a.imem_addr} !== {1'b1, 11'd60}) begin
      fails++;
      $display("FAIL b2b_issue: got rd=%b a=%0d want 1/60", bus_a.imem_rd_en, bus_a.imem_addr);
    end
    cyc_a(1'b1, 1'b0, '0);
    cyc_a(1'b1, 1'b0, '0);
    tests++;
    if ({bus_a.out_valid, bus_a.out_pc, bus_a.out_instr} !== {1'b1, 11'd60, 32'd160}) begin
      fails++;
      $display("FAIL b2b_deliver: got v=%b pc=%0d i=%0d want 1/60/160",
               bus_a.out_valid, bus_a.out_pc, bus_a.out_instr);
    end
  endtask

  task automatic test_redirect_pop();
    bit found;
    found = 1'b0;
    cyc_a(1'b1, 1'b1, 11'd0);
    for (int i = 0; i < 12 && !found; i++) begin
      cyc_a(1'b1, 1'b0, '0);
      if (bus_a.out_valid === 1'b1 && bus_a.out_pc === 11'd3) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL redirpop_wait_pc3: got found=0 want 1");
    end
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = 11'd20;
    #1;
    tests++;
    if ({bus_a.imem_rd_en, bus_a.out_valid, bus_a.out_pc} !== {1'b0, 1'b1, 11'd3}) begin
      fails++;
      $display("FAIL redirpop_cycle: got rd=%b v=%b pc=%0d want 0/1/3",
               bus_a.imem_rd_en, bus_a.out_valid, bus_a.out_pc);
    end
    for (int c = 1; c <= 3; c++) begin
      cyc_a(1'b1, 1'b0, '0);
      tests++;
      if (c < 3 && bus_a.out_valid !== 1'b0) begin
        fails++;
        $display("FAIL redirpop_gap: got v=%b pc=%0d want v=0", bus_a.out_valid, bus_a.out_pc);
      end else if (c == 3 && {bus_a.out_valid, bus_a.out_pc, bus_a.out_instr}
                   !== {1'b1, 11'd20, 32'd120}) begin
        fails++;
        $display("FAIL redirpop_next: got v=%b pc=%0d i=%0d want 1/20/120",
                 bus_a.out_valid, bus_a.out_pc, bus_a.out_instr);
      end
    end
  endtask

  task automatic test_backpressure();
    int rd_count;
    rd_count = 0;
    cyc_a(1'b0, 1'b1, 11'd0);
    for (int c = 0; c < 10; c++) begin
      cyc_a(1'b0, 1'b0, '0);
      if (bus_a.imem_rd_en === 1'b1) rd_count++;
    end
    tests++;
    if (rd_count != DEPTH) begin
      fails++;
      $display("FAIL bp_credit_limit: got %0d reads want %0d", rd_count, DEPTH);
    end
    tests++;
    if ({bus_a.out_valid, bus_a.out_pc} !== {1'b1, 11'd0}) begin
      fails++;
      $display("FAIL bp_head_hold: got v=%b pc=%0d want 1/0", bus_a.out_valid, bus_a.out_pc);
    end
    for (int k = 0; k < 10; k++) begin
      cyc_a(1'b1, 1'b0, '0);
      tests++;
      if ({bus_a.out_valid, bus_a.out_pc, bus_a.out_instr}
          !== {1'b1, AW_A'(k), IW'(k + 100)}) begin
        fails++;
        $display("FAIL bp_release: got v=%b pc=%0d i=%0d want 1/%0d/%0d",
                 bus_a.out_valid, bus_a.out_pc, bus_a.out_instr, k, k + 100);
      end
    end
  endtask

  // Model: deliveries and issues are each a consecutive run from the last redirect target;
  // issued-but-undelivered reads never exceed DEPTH.
  task automatic test_random();
    logic [AW_A-1:0] exp_del, exp_fetch, rpc;
    logic            rdy, rv;
    int              outst, delivered;
    cyc_a(1'b1, 1'b1, 11'd100);
    exp_del   = 11'd100;
    exp_fetch = 11'd100;
    outst     = 0;
    delivered = 0;
    for (int n = 0; n < 1500; n++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 29) == 0);
      rpc = AW_A'($urandom_range(0, 1000));
      cyc_a(rdy, rv, rpc);
      if (rv) begin
        tests++;
        if (bus_a.imem_rd_en !== 1'b0) begin
          fails++;
          $display("FAIL rand_rd_in_redirect: got %b want 0", bus_a.imem_rd_en);
        end
      end
      if (bus_a.imem_rd_en === 1'b1) begin
        tests++;
        if (bus_a.imem_addr !== exp_fetch) begin
          fails++;
          $display("FAIL rand_issue_addr: got %0d want %0d", bus_a.imem_addr, exp_fetch);
        end
        exp_fetch++;
        outst++;
      end
      if (bus_a.out_valid === 1'b1 && rdy) begin
        tests++;
        if ({bus_a.out_pc, bus_a.out_instr} !== {exp_del, IW'(exp_del) + IW'(100)}) begin
          fails++;
          $display("FAIL rand_deliver: got pc=%0d i=%0d want pc=%0d i=%0d",
                   bus_a.out_pc, bus_a.out_instr, exp_del, IW'(exp_del) + IW'(100));
        end
        exp_del++;
        outst--;
        delivered++;
      end else if (bus_a.out_valid !== 1'b1) begin
        tests++;
        if ({bus_a.out_valid, bus_a.out_pc, bus_a.out_instr} !== {1'b0, 11'd0, NOP}) begin
          fails++;
          $display("FAIL rand_empty_bubble: got v=%b pc=%0d i=%h want 0/0/%h",
                   bus_a.out_valid, bus_a.out_pc, bus_a.out_instr, NOP);
        end
      end
      tests++;
      if (outst > DEPTH) begin
        fails++;
        $display("FAIL rand_credit: got outstanding=%0d want <=%0d", outst, DEPTH);
      end
      if (rv) begin
        exp_del   = rpc;
        exp_fetch = rpc;
        outst     = 0;
      end
    end
    tests++;
    if (delivered < 300) begin
      fails++;
      $display("FAIL rand_throughput: got %0d deliveries want >=300", delivered);
    end
    cyc_a(1'b1, 1'b0, '0);
  endtask

  task automatic test_end_of_memory();
    logic exp_rd, exp_v;
    cyc_b(1'b1, 1'b1, 4'd13);
    for (int c = 1; c <= 8; c++) begin
      cyc_b(1'b1, 1'b0, '0);
      exp_rd = (c <= 3);
      exp_v  = (c >= 3 && c <= 5);
      tests++;
      if (bus_b.imem_rd_en !== exp_rd || (exp_rd && bus_b.imem_addr !== AW_B'(12 + c))) begin
        fails++;
        $display("FAIL eom_issue c%0d: got rd=%b a=%0d want rd=%b a=%0d",
                 c, bus_b.imem_rd_en, bus_b.imem_addr, exp_rd, 12 + c);
      end
      tests++;
      if (bus_b.fetch_halted !== (c >= 4)) begin
        fails++;
        $display("FAIL eom_halted c%0d: got %b want %b", c, bus_b.fetch_halted, (c >= 4));
      end
      tests++;
      if (bus_b.out_valid !== exp_v ||
          (exp_v && {bus_b.out_pc, bus_b.out_instr} !== {AW_B'(10 + c), IW'(110 + c)})) begin
        fails++;
        $display("FAIL eom_deliver c%0d: got v=%b pc=%0d i=%0d want v=%b pc=%0d i=%0d",
                 c, bus_b.out_valid, bus_b.out_pc, bus_b.out_instr, exp_v, 10 + c, 110 + c);
      end
    end
    cyc_b(1'b1, 1'b1, 4'd2);
    cyc_b(1'b1, 1'b0, '0);
    tests++;
    if ({bus_b.fetch_halted, bus_b.imem_rd_en, bus_b.imem_addr} !== {1'b0, 1'b1, 4'd2}) begin
      fails++;
      $display("FAIL eom_unhalt: got h=%b rd=%b a=%0d want 0/1/2",
               bus_b.fetch_halted, bus_b.imem_rd_en, bus_b.imem_addr);
    end
    cyc_b(1'b1, 1'b0, '0);
    cyc_b(1'b1, 1'b0, '0);
    tests++;
    if ({bus_b.out_valid, bus_b.out_pc, bus_b.out_instr} !== {1'b1, 4'd2, 32'd102}) begin
      fails++;
      $display("FAIL eom_restart: got v=%b pc=%0d i=%0d want 1/2/102",
               bus_b.out_valid, bus_b.out_pc, bus_b.out_instr);
    end
  endtask

  task automatic test_reset_midop();
    repeat (8) cyc_a(1'b0, 1'b0, '0);
    tests++;
    if (bus_a.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL midrst_precondition: got v=%b want 1", bus_a.out_valid);
    end
    #1 rst = 1'b0;
    #1;
    tests++;
    if ({bus_a.out_valid, bus_a.out_instr, bus_a.out_pc, bus_a.imem_rd_en, bus_a.imem_addr,
         bus_a.fetch_halted} !== {1'b0, NOP, 11'd0, 1'b0, 11'd0, 1'b0}) begin
      fails++;
      $display("FAIL midrst_async: got v=%b i=%h pc=%0d rd=%b a=%0d h=%b want 0/%h/0/0/0/0",
               bus_a.out_valid, bus_a.out_instr, bus_a.out_pc, bus_a.imem_rd_en,
               bus_a.imem_addr, bus_a.fetch_halted, NOP);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_a.out_ready = 1'b1;
    #1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) cyc_a(1'b1, 1'b0, '0);
      tests++;
      if (c < 3 && (bus_a.out_valid !== 1'b0 || bus_a.imem_rd_en !== (c == 1 || c == 2))) begin
        fails++;
        $display("FAIL midrst_restart c%0d: got v=%b rd=%b want v=0 rd=%b",
                 c, bus_a.out_valid, bus_a.imem_rd_en, (c == 1 || c == 2));
      end else if (c >= 3 && {bus_a.out_valid, bus_a.out_pc, bus_a.out_instr}
                   !== {1'b1, AW_A'(c - 3), IW'(c + 97)}) begin
        fails++;
        $display("FAIL midrst_restart c%0d: got v=%b pc=%0d i=%0d want 1/%0d/%0d",
                 c, bus_a.out_valid, bus_a.out_pc, bus_a.out_instr, c - 3, c + 97);
      end
    end
  endtask

  initial begin
    bus_a.out_ready = 1'b1; bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = '0;
    bus_b.out_ready = 1'b1; bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = '0;
    test_reset();
    test_startup();
    test_redirect();
    test_back_to_back();
    test_redirect_pop();
    test_backpressure();
    test_random();
    test_end_of_memory();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached want completion");
    $fatal(1);
  end

endmodule
